// File: rtl/qspi_pkg.sv
// Shared types and constants for the QSPI flash responder.
package qspi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_IGNORE
    } qspi_state_e;

    localparam logic [7:0] QSPI_CMD_READ  = 8'h03;
    localparam logic [7:0] QSPI_CMD_QREAD = 8'h6B;
    localparam int         QSPI_ADDR_BITS = 24;

endpackage

// File: rtl/qspi_sync_edge.sv
// Two-flop synchronizer with one extra delay stage for rise/fall pulse detection.
module qspi_sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q, s2_q, s3_q;

    // All stages reset low so a line held low across reset never looks like a fresh fall.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign level_o = s2_q;
    assign rise_o  = s2_q & ~s3_q;
    assign fall_o  = ~s2_q & s3_q;

endmodule

// File: rtl/qspi_flash_responder.sv
// QSPI flash target: oversamples SCK/CS/IO, decodes 0x03 and 0x6B reads and
// streams bytes from a preloadable internal array.
module qspi_flash_responder
    import qspi_pkg::*;
#(
    parameter int MEM_SZ    = 262144,
    parameter int ADDR_W    = $clog2(MEM_SZ),
    parameter int DUMMY_CYC = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              qspi_ck_i,
    input  logic              qspi_cs_i,
    input  logic [3:0]        qspi_io_i,
    input  logic [3:0]        qspi_io_t_i,
    output logic [3:0]        qspi_io_o,
    input  logic              load_we_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic [7:0]        load_data_i,
    output logic              busy_o,
    output qspi_state_e       dbg_state_o
);

    localparam logic [4:0]        CMD_LAST   = 5'd7;
    localparam logic [4:0]        ADDR_LAST  = 5'(QSPI_ADDR_BITS - 1);
    localparam logic [4:0]        DUMMY_LAST = 5'(DUMMY_CYC - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);

    logic ck_level, ck_rise, ck_fall;
    logic cs_level, cs_rise, cs_fall;
    logic [3:0] io_s1, io_s2;

    qspi_sync_edge u_sync_ck (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .d_i     (qspi_ck_i),
        .level_o (ck_level),
        .rise_o  (ck_rise),
        .fall_o  (ck_fall)
    );

    qspi_sync_edge u_sync_cs (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .d_i     (qspi_cs_i),
        .level_o (cs_level),
        .rise_o  (cs_rise),
        .fall_o  (cs_fall)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            io_s1 <= 4'h0;
            io_s2 <= 4'h0;
        end else begin
            io_s1 <= qspi_io_i;
            io_s2 <= io_s1;
        end
    end

    logic [7:0] mem [0:MEM_SZ-1];

    always_ff @(posedge clk_i) begin
        if (load_we_i) mem[load_addr_i] <= load_data_i;
    end

    qspi_state_e       state;
    logic              quad;
    logic              armed;
    logic [4:0]        bit_cnt;
    logic [6:0]        cmd_sr;
    logic [ADDR_W-2:0] addr_sr;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        shreg;
    logic [3:0]        io_q;

    // Upper address bits simply shift out of the ADDR_W-wide window.
    logic [7:0]        cmd_next;
    logic [ADDR_W-1:0] addr_next;
    logic              byte_last;

    assign cmd_next  = {cmd_sr, io_s2[0]};
    assign addr_next = {addr_sr, io_s2[0]};
    assign byte_last = quad ? (bit_cnt == 5'd1) : (bit_cnt == 5'd7);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= ST_IDLE;
            quad    <= 1'b0;
            armed   <= 1'b0;
            bit_cnt <= 5'd0;
            cmd_sr  <= 7'd0;
            addr_sr <= '0;
            addr    <= '0;
            shreg   <= 8'h00;
            io_q    <= 4'h0;
        end else begin
            // A transaction may only start after CS has been seen released since reset.
            if (cs_level) armed <= 1'b1;

            if (cs_rise) begin
                state   <= ST_IDLE;
                bit_cnt <= 5'd0;
                io_q    <= 4'h0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        io_q <= 4'h0;
                        if (cs_fall && armed) begin
                            state   <= ST_CMD;
                            bit_cnt <= 5'd0;
                        end
                    end
                    ST_CMD: begin
                        if (ck_rise) begin
                            cmd_sr  <= cmd_next[6:0];
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == CMD_LAST) begin
                                bit_cnt <= 5'd0;
                                if (cmd_next == QSPI_CMD_READ) begin
                                    state <= ST_ADDR;
                                    quad  <= 1'b0;
                                end else if (cmd_next == QSPI_CMD_QREAD) begin
                                    state <= ST_ADDR;
                                    quad  <= 1'b1;
                                end else begin
                                    state <= ST_IGNORE;
                                end
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (ck_rise) begin
                            addr_sr <= addr_next[ADDR_W-2:0];
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == ADDR_LAST) begin
                                bit_cnt <= 5'd0;
                                addr    <= addr_next;
                                shreg   <= mem[addr_next];
                                state   <= quad ? ST_DUMMY : ST_DATA;
                            end
                        end
                    end
                    ST_DUMMY: begin
                        if (ck_rise) begin
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == DUMMY_LAST) begin
                                bit_cnt <= 5'd0;
                                state   <= ST_DATA;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (ck_fall) begin
                            if (quad) begin
                                io_q  <= shreg[7:4];
                                shreg <= {shreg[3:0], 4'h0};
                            end else begin
                                io_q  <= {2'b00, shreg[7], 1'b0};
                                shreg <= {shreg[6:0], 1'b0};
                            end
                            if (byte_last) begin
                                bit_cnt <= 5'd0;
                                addr    <= addr + ADDR_ONE;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end else if (bit_cnt == 5'd0) begin
                            // Keep refreshing the pending byte so late preload writes are seen.
                            shreg <= mem[addr];
                        end
                    end
                    ST_IGNORE: io_q <= 4'h0;
                    default: begin
                        state <= ST_IDLE;
                        io_q  <= 4'h0;
                    end
                endcase
            end
        end
    end

    assign qspi_io_o   = io_q;
    assign busy_o      = armed & ~cs_level;
    assign dbg_state_o = state;

    logic unused_ok;
    assign unused_ok = ^{qspi_io_t_i, io_s2[3:1], ck_level};

endmodule

// File: doc/qspi_flash_responder.md
# qspi_flash_responder

Synthesizable QSPI serial-flash responder: the target end of the external-storage QSPI link that `toplevel_498` drives as initiator. It oversamples the initiator's SCK/CS/IO on the system clock, decodes single-line and quad-output read commands, and returns bytes from an internal preloadable byte array. It replaces the behavioural stub in simulation and serves as an FPGA flash emulator when no physical flash is fitted.

## Interface
- `MEM_SZ`, 262144: array size in bytes; power of two.
- `ADDR_W`, $clog2(MEM_SZ): effective address bits; upper bits of the 24-bit address are ignored.
- `DUMMY_CYC`, 8: dummy SCK cycles for command 0x6B.

- `clk_i`  in  1  system clock; must be at least 4x the SCK frequency.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `qspi_ck_i`  in  1  initiator SCK (SPI mode 0).
- `qspi_cs_i`  in  1  initiator chip select, active low.
- `qspi_io_i`  in  4  initiator IO out; bit 0 = MOSI.
- `qspi_io_t_i`  in  4  initiator tristate (1 = released); informational only, not used for decoding.
- `qspi_io_o`  out  4  responder data toward initiator `io_i`; bit 1 = MISO in single mode.
- `load_we_i`  in  1  preload write strobe.
- `load_addr_i`  in  ADDR_W  preload byte address.
- `load_data_i`  in  8  preload byte.
- `busy_o`  out  1  CS currently asserted, as synchronized.

## Operation
- `qspi_ck_i`, `qspi_cs_i` and `qspi_io_i` each pass through a 2-flop synchronizer. Rising and falling SCK edges are detected from the synchronized SCK.
- IO is sampled on a detected SCK rising edge. `qspi_io_o` is updated on a detected SCK falling edge.
- FSM states: IDLE, CMD, ADDR, DUMMY, DATA, IGNORE.
  - IDLE: a synchronized CS fall moves to CMD and clears `bit_cnt` (5 bits).
  - CMD: shift 8 bits from io[0], MSB first. After bit 8:
    - 0x03 → ADDR, mode single.
    - 0x6B → ADDR, mode quad.
    - any other value → IGNORE.
  - ADDR: shift 24 bits from io[0], MSB first. After bit 24:
    - mode single → DATA.
    - mode quad → DUMMY.
    - The byte at `addr[ADDR_W-1:0]` is fetched into `shreg` in the same cycle.
  - DUMMY: count `DUMMY_CYC` rising edges, then go to DATA.
  - DATA:
    - Single mode: `qspi_io_o[1]` = next bit, MSB first; other bits 0.
    - Quad mode: `qspi_io_o` = next nibble, high nibble first.
    - On the last bit or nibble of a byte, `addr` increments modulo MEM_SZ (wraps to 0 after MEM_SZ-1), and the next byte is loaded into `shreg` before the following falling edge.
  - IGNORE: hold outputs at 0.
- A synchronized CS rise in any state returns to IDLE on the next clk and sets `qspi_io_o` to 0. A partial command or address is discarded.
- Preload writes have priority over nothing: the array is single-write, single-read. A `load_we_i` during DATA to the address being prefetched returns the new byte.
- Reset: state IDLE, counters 0, `qspi_io_o`=0, `busy_o`=0. Array contents are not reset.

## Timing
- Input-to-decision latency: 2 clk (synchronizer) + 1 clk (edge detect).
- `qspi_io_o` changes 3-4 clk after the SCK falling edge at the pin. It is therefore stable before the next SCK rising edge whenever SCK ≤ clk/4.
- First data bit or nibble is presented on the falling edge after the last address bit (0x03) or the last dummy cycle (0x6B).
- An SCK edge coincident with a CS rise is ignored; CS wins.
- Reset asserted mid-transfer: outputs reach 0 asynchronously. After release, the responder stays in IDLE until a fresh CS fall.

## Structure
- Package `qspi_pkg`:
  - `qspi_state_e` enum.
  - constants `QSPI_CMD_READ`=8'h03 and `QSPI_CMD_QREAD`=8'h6B.
  - `QSPI_ADDR_BITS`=24.
- Sub-module `qspi_sync_edge`: 2-flop synchronizer plus rise/fall pulse outputs, instantiated for SCK and CS; IO uses plain synchronizers.
- Byte array inferred as single-port-write/async-or-registered-read RAM inside the top module.

## Test plan
- Preload 0x000100..0x000103 = A5,3C,F0,0F; command 0x03, address 0x000100, 32 SCK → MISO bytes A5,3C,F0,0F.
- Command 0x6B, address 0x000102, 8 dummy, 4 SCK → io_o nibbles F,0,0,F.
- MEM_SZ=256, preload [0xFF]=0x11 and [0x00]=0x22; 0x6B at 0x0000FF, 4 nibbles → 1,1,2,2 (wrap).
- Command 0x9F → IGNORE, io_o=0 for 64 SCK. CS rise then a 0x03 read succeeds.
- CS deasserted after 12 address bits → IDLE, busy_o=0 within 3 clk. A following full read returns correct data.
- rst_ni pulsed low mid-DATA → io_o=0 immediately. No data is driven until the next CS fall and complete command.
